// File: rtl/boolean_lut_engine.sv
// boolean_lut_engine: run-time programmable N_IN-input boolean function evaluated on CH channels,
// with a serially loaded, double-buffered truth table.
module boolean_lut_engine #(
    parameter int N_IN = 3,
    parameter int CH   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_valid,
    input  logic                  cfg_bit,
    output logic                  cfg_done,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH*N_IN-1:0]    x,
    output logic                  out_valid,
    output logic [CH-1:0]         y,
    output logic [2**N_IN-1:0]    table_q
);
    localparam int T = 2 ** N_IN;
    localparam logic [N_IN:0] LAST = (N_IN + 1)'(T - 1);
    typedef enum logic {IDLE, LOAD} state_t;
    state_t        state_q, state_d;
    logic [N_IN:0] cnt_q, cnt_d;
    logic [T-1:0]  shadow_q, shadow_d, act_q, act_d;
    logic          actv_q, actv_d, done_q, done_d, ov_q, ov_d;
    logic [CH-1:0] y_q, y_d, lut;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            act_q    <= '0;
            actv_q   <= 1'b0;
            done_q   <= 1'b0;
            ov_q     <= 1'b0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            act_q    <= act_d;
            actv_q   <= actv_d;
            done_q   <= done_d;
            ov_q     <= ov_d;
            y_q      <= y_d;
        end
    end
    // A restart always wins, even over the final bit; the swap merges the final bit directly.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        act_d    = act_q;
        actv_d   = actv_q;
        done_d   = 1'b0;
        if (cfg_start) begin
            state_d  = LOAD;
            cnt_d    = '0;
            shadow_d = '0;
        end else if (state_q == LOAD && cfg_valid) begin
            shadow_d[cnt_q[N_IN-1:0]] = cfg_bit;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                act_d   = shadow_d;
                actv_d  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end
    always_comb begin
        lut = '0;
        for (int c = 0; c < CH; c++) lut[c] = act_q[x[c*N_IN +: N_IN]];
    end
    assign ov_d      = in_valid && actv_q;
    assign y_d       = ov_d ? lut : y_q;
    assign cfg_done  = done_q;
    assign busy      = (state_q == LOAD);
    assign in_ready  = actv_q;
    assign out_valid = ov_q;
    assign y         = y_q;
    assign table_q   = act_q;
endmodule
